// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the FIFO read-side drain engine.
// The framing state, default sizes and buffer entry layout live here.
package fifo_rd_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_BURST = 4;
    localparam int DEF_CNT_W = 16;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } frame_state_e;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic                 sop;
        logic                 eop;
    } entry_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry registered buffer with push/pop/flush.
// Entry 0 is always the head; entry 1 is only meaningful when occ is 2.
module fifo_rd_skid #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   occ
);

    logic [W-1:0] ent0_q, ent0_d;
    logic [W-1:0] ent1_q, ent1_d;
    logic [1:0]   occ_q, occ_d;
    logic         do_pop;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        do_pop = pop && (occ_q != 2'd0);
        if (flush) begin
            occ_d = 2'd0;
        end else if (push && do_pop) begin
            // Head leaves, tail fills: occupancy unchanged, order kept.
            if (occ_q == 2'd1) begin
                ent0_d = din;
            end else begin
                ent0_d = ent1_q;
                ent1_d = din;
            end
        end else if (push) begin
            if (occ_q == 2'd0) begin
                ent0_d = din;
            end else begin
                ent1_d = din;
            end
            occ_d = occ_q + 2'd1;
        end else if (do_pop) begin
            ent0_d = ent1_q;
            occ_d  = occ_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign head = ent0_q;
    assign occ  = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side drain engine: reads words into a 2-entry buffer and
// streams them out as valid/ready bursts with start/end markers.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BURST = DEF_BURST,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fifo_rd_en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_sop,
    output logic             m_eop,
    input  logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] rd_count
);

    localparam int IDX_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(BURST - 1);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             sop;
        logic             eop;
    } word_t;

    frame_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       occ;
    word_t            push_w;
    word_t            head_w;
    logic             push;
    logic             pop;
    logic             is_last;

    // Read strobe never looks at m_ready, only registered occupancy.
    assign fifo_rd_en = !fifo_empty && (occ != 2'd2) && !flush;
    assign push       = fifo_rd_en;
    assign pop        = m_valid && m_ready;
    assign is_last    = (idx_q == LAST);

    always_comb begin
        push_w.data = fifo_data;
        push_w.sop  = (idx_q == '0);
        push_w.eop  = is_last;
        idx_d       = idx_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        if (flush) begin
            idx_d   = '0;
            state_d = IDLE;
        end else if (push) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (is_last) begin
                idx_d   = '0;
                state_d = IDLE;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = IN_FRAME;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    fifo_rd_skid #(
        .W($bits(word_t))
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .flush(flush),
        .din  (push_w),
        .head (head_w),
        .occ  (occ)
    );

    assign m_valid  = (occ != 2'd0);
    assign m_data   = head_w.data;
    assign m_sop    = head_w.sop && m_valid;
    assign m_eop    = head_w.eop && m_valid;
    assign busy     = (occ != 2'd0) || (state_q == IN_FRAME);
    assign rd_count = cnt_q;

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain engine for the team's synchronous FIFO. It pulls words through the FIFO's `rd_en`/`empty` port and registers them into a 2-entry output buffer. It presents them downstream as a valid/ready stream framed into fixed-length bursts with start/end markers. It sits between the FIFO and any streaming consumer, and decouples the consumer's backpressure from the FIFO's combinational read path.

## Interface
Parameters:
- `WIDTH`, 16, data word width; must match the FIFO.
- `BURST`, 4, words per frame; legal range 1..256.
- `CNT_W`, 16, width of the `rd_count` statistics counter.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fifo_rd_en`  out  1  read strobe to the FIFO.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  WIDTH  FIFO read data. Valid combinationally in the same cycle as `fifo_rd_en && !fifo_empty`; 0 otherwise.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer accepts the word.
- `m_data`  out  WIDTH  output word.
- `m_sop`  out  1  first word of a frame.
- `m_eop`  out  1  last word of a frame.
- `flush`  in  1  synchronous abort: drop buffered words and restart framing.
- `busy`  out  1  buffer non-empty or frame partially emitted.
- `rd_count`  out  CNT_W  total FIFO words read since reset, wrapping.

## Operation
- Buffer: 2 entries, each holding {data, sop, eop}. Occupancy `occ` is 0..2. Pop happens on `m_valid && m_ready`.
- `fifo_rd_en = !fifo_empty && occ < 2 && !flush`. It depends only on registered state and FIFO/flush inputs, never on `m_ready`.
- Push: on `fifo_rd_en` high, `fifo_data` is captured into the buffer tail in the same edge.
- Frame index `idx` (0..BURST-1) advances on every push:
  - the pushed entry gets sop=(idx==0) and eop=(idx==BURST-1);
  - `idx` wraps BURST-1 -> 0;
  - with BURST=1, every word has sop=eop=1.
- Framing FSM:
  - IDLE (idx==0, no partial frame);
  - IN_FRAME (0<idx);
  - IDLE -> IN_FRAME on a push when BURST>1;
  - IN_FRAME -> IDLE on the push that carries eop, or on flush.
- Simultaneous push and pop: `occ` is unchanged, and order is preserved (head pops, tail fills).
- `flush`: at the next edge, `occ`<=0 and idx<=0 (state IDLE), and there is no FIFO read that cycle. Any pop in the flush cycle is ignored; the consumer must not rely on it. `rd_count` is not cleared.
- `rd_count` increments by 1 per push and wraps 2^CNT_W-1 -> 0.
- `busy = (occ != 0) || (state == IN_FRAME)`.
- The block never drops or duplicates a word except on flush or reset.

## Timing
- Reset values:
  - `m_valid`=0, `m_data`=0, `m_sop`=0, `m_eop`=0;
  - `busy`=0, `rd_count`=0, occ=0, idx=0, state IDLE;
  - `fifo_rd_en` follows its equation (0 while `fifo_empty`=1).
- Latency: a word read in cycle N is on `m_data` with `m_valid`=1 in cycle N+1.
- Throughput: 1 word/cycle sustained while the FIFO is non-empty and `m_ready`=1 (steady state occ=1).
- Backpressure: `m_ready`=0 fills the buffer to 2, and then `fifo_rd_en` drops. Once `m_valid` is high, `m_data`/`m_sop`/`m_eop` must hold stable until accepted.
- FIFO empty while occ>0: the buffer keeps draining, and `m_valid` falls the cycle after the last pop.
- Reset mid-frame: everything clears immediately. The next word after reset carries sop=1.

## Structure
- Package `fifo_rd_pkg`:
  - framing state enum {IDLE, IN_FRAME};
  - default `WIDTH`/`BURST`/`CNT_W` localparams;
  - packed entry struct {data, sop, eop}.
- Sub-module `fifo_rd_skid`: 2-entry registered buffer with push/pop/flush, `occ` output, and head entry output.
- The top level holds `idx`, the FSM, `rd_count`, and `fifo_rd_en` logic.

## Test plan
- Reset then preload FIFO with 0x0001..0x0008, `m_ready`=1, BURST=4:
  - 8 words out on consecutive cycles, first at 1 cycle after the first read;
  - sop on 0x0001/0x0005, eop on 0x0004/0x0008;
  - `rd_count`=8.
- Backpressure, 6 words queued, `m_ready`=0 for 5 cycles:
  - `fifo_rd_en` high exactly 2 cycles, then low;
  - `m_data`=0x0001 held stable;
  - on release, all 6 words arrive in order.
- FIFO empties mid-frame after word 2 and refills 10 cycles later:
  - `busy` stays 1;
  - word 3 has sop=0, and word 4 has eop=1.
- `flush` asserted with occ=2 and idx=3:
  - next cycle `m_valid`=0 and `busy`=0;
  - the next word read carries sop=1;
  - no FIFO read occurs in the flush cycle.
- `rst` asserted mid-frame with `m_valid`=1:
  - outputs drop to 0 without a clock edge;
  - `rd_count`=0.
- CNT_W=4, 17 words streamed: `rd_count` reads 1 at the end (wrap from 15 to 0).
